edge_code_encoder: RTL and testbench

//  Inverse of the per-channel edge-placement decoder. It turns a requested edge delay into the
//  10-bit binary-weighted v_value code that the decoder maps back to a start edge.

---
 rtl/edge_code_encoder.sv | 150 +++++++++++++++
 tb/tb_edge_code_encoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_code_encoder.sv
// edge_code_encoder
//   Converts a requested edge delay (in 0.05 time units) into the binary-weighted
//   v_value code understood by the per-channel edge-placement decoder. The code
//   is found by successive approximation, MSB first, one bit per clock, over the
//   weight table 5000, 2500, 1250, 624, 312, 156, 78, 39 (sum 9959).
//
//   Build option: define EDGE_ENC_RESIDUE_EN to add the out_residue port
//   (target minus decoded value). Without it the port and register are absent.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     request valid
//   in_ready     request can be accepted (IDLE only)
//   in_target    requested delay, 0.05-unit steps
//   out_valid    result valid (DONE)
//   out_ready    consumer accepts result
//   out_code     encoded v_value; bits above [7:0] are always 0
//   out_ovf      target exceeded 9959; code saturated at 8'hFF
//   out_residue  target - decoded value (EDGE_ENC_RESIDUE_EN only)
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CONV  | deciding one code bit per cycle, bit 7 down to bit 0
// DONE  | result presented, held until out_ready

module edge_code_encoder #(
   parameter int TARGET_W = 16,
   parameter int CODE_W   = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [TARGET_W-1:0] in_target,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CODE_W-1:0]   out_code,
   output logic                out_ovf
`ifdef EDGE_ENC_RESIDUE_EN
   ,
   output logic [TARGET_W-1:0] out_residue
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [TARGET_W-1:0] W_SUM = TARGET_W'(9959);

   state_t              state;
   state_t              state_nxt;
   logic [TARGET_W-1:0] target_q;
   logic [TARGET_W-1:0] acc_q;
   logic [7:0]          code_q;
   logic [2:0]          idx_q;

   logic [TARGET_W:0]   trial;
   logic                take;
   logic [TARGET_W-1:0] acc_nxt;
   logic [7:0]          code_nxt;

   function automatic logic [TARGET_W-1:0] weight(input logic [2:0] i);
      logic [TARGET_W-1:0] w;
      case (i)
         3'd7:    w = TARGET_W'(5000);
         3'd6:    w = TARGET_W'(2500);
         3'd5:    w = TARGET_W'(1250);
         3'd4:    w = TARGET_W'(624);
         3'd3:    w = TARGET_W'(312);
         3'd2:    w = TARGET_W'(156);
         3'd1:    w = TARGET_W'(78);
         default: w = TARGET_W'(39);
      endcase
      return w;
   endfunction

   // Trial sum carries one extra bit so a large accumulator never wraps past the target.
   always_comb begin
      trial    = {1'b0, acc_q} + {1'b0, weight(idx_q)};
      take     = (trial <= {1'b0, target_q});
      acc_nxt  = acc_q;
      code_nxt = code_q;
      if (take) begin
         acc_nxt         = trial[TARGET_W-1:0];
         code_nxt[idx_q] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)       state_nxt = CONV;
         CONV:    if (idx_q == 3'd0)  state_nxt = DONE;
         DONE:    if (out_ready)      state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         target_q    <= '0;
         acc_q       <= '0;
         code_q      <= '0;
         idx_q       <= '0;
         out_code    <= '0;
         out_ovf     <= 1'b0;
`ifdef EDGE_ENC_RESIDUE_EN
         out_residue <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  target_q <= in_target;
                  acc_q    <= '0;
                  code_q   <= '0;
                  idx_q    <= 3'd7;
               end
            end
            CONV: begin
               acc_q  <= acc_nxt;
               code_q <= code_nxt;
               idx_q  <= idx_q - 3'd1;
               // Last bit decided: publish the result together with the DONE transition.
               if (idx_q == 3'd0) begin
                  out_code    <= {{(CODE_W-8){1'b0}}, code_nxt};
                  out_ovf     <= (target_q > W_SUM);
`ifdef EDGE_ENC_RESIDUE_EN
                  out_residue <= target_q - acc_nxt;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_edge_code_encoder.sv
// tb_edge_code_encoder
//   Scoreboard bench for edge_code_encoder. The driver pushes expected results
//   when it issues a request; a monitor on the falling edge pops and compares
//   whenever out_valid rises, and checks output stability under backpressure.
//   Works with or without EDGE_ENC_RESIDUE_EN.

module tb_edge_code_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_target = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [9:0]  out_code;
   logic        out_ovf;
`ifdef EDGE_ENC_RESIDUE_EN
   logic [15:0] out_residue;
`endif

   always #5 clk = ~clk;

   edge_code_encoder #(.TARGET_W(16), .CODE_W(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_target  (in_target),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_code   (out_code),
      .out_ovf    (out_ovf)
`ifdef EDGE_ENC_RESIDUE_EN
      ,
      .out_residue(out_residue)
`endif
   );

   typedef struct packed {
      logic [9:0]  code;
      logic        ovf;
      logic [15:0] res;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic int decode(input int c);
      int s;
      s = 0;
      if (c[7]) s += 5000;
      if (c[6]) s += 2500;
      if (c[5]) s += 1250;
      if (c[4]) s += 624;
      if (c[3]) s += 312;
      if (c[2]) s += 156;
      if (c[1]) s += 78;
      if (c[0]) s += 39;
      return s;
   endfunction

   // Weights are super-increasing, so decode is monotonic in the code: the
   // truncating encoding is the largest code whose decoded value fits.
   function automatic exp_t model(input int t);
      exp_t r;
      int   best;
      best = 0;
      for (int c = 255; c >= 0; c--) begin
         if (decode(c) <= t) begin
            best = c;
            break;
         end
      end
      r.code = 10'(best);
      r.ovf  = (t > 9959);
      r.res  = 16'(t - decode(best));
      return r;
   endfunction

   function automatic exp_t mk(input int code, input int ovf, input int res);
      exp_t r;
      r.code = 10'(code);
      r.ovf  = ovf[0];
      r.res  = 16'(res);
      return r;
   endfunction

   // Monitor
   exp_t cur;
   bit   showing = 1'b0;
   int   ac;
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         showing = 1'b0;
      end else begin
         if (in_valid && in_ready) acc_q.push_back(cyc);
         if (out_valid) begin
            if (!showing) begin
               if (exp_q.size() == 0 || acc_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output actual_code=%0d required=no_output", out_code);
                  cur = mk(int'(out_code), int'(out_ovf), 0);
               end else begin
                  cur = exp_q.pop_front();
                  ac  = acc_q.pop_front();
                  check("latency", cyc - ac, 9);
                  check("code", int'(out_code), int'(cur.code));
                  check("ovf", int'(out_ovf), int'(cur.ovf));
`ifdef EDGE_ENC_RESIDUE_EN
                  check("residue", int'(out_residue), int'(cur.res));
`endif
               end
               showing = 1'b1;
            end else begin
               check("hold_code", int'(out_code), int'(cur.code));
               check("hold_ovf", int'(out_ovf), int'(cur.ovf));
               check("hold_in_ready", int'(in_ready), 0);
            end
            if (out_ready) showing = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int t, input exp_t e);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         check("send_timeout_in_ready", int'(in_ready), 1);
      end else begin
         in_valid  = 1'b1;
         in_target = 16'(t);
         exp_q.push_back(e);
         tick();
         in_valid  = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check("drain_timeout_pending", exp_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int t;

      // Reset held for 3 cycles
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_code", int'(out_code), 0);
      check("rst_out_ovf", int'(out_ovf), 0);
`ifdef EDGE_ENC_RESIDUE_EN
      check("rst_out_residue", int'(out_residue), 0);
`endif

      // Directed, hand-computed
      send(5000,  mk(10'h080, 0, 0));
      send(7539,  mk(10'h0C1, 0, 0));
      send(38,    mk(10'h000, 0, 38));
      send(39,    mk(10'h001, 0, 0));
      send(0,     mk(10'h000, 0, 0));
      send(3,     mk(10'h000, 0, 3));
      send(9958,  mk(10'h0FE, 0, 38));
      send(9959,  mk(10'h0FF, 0, 0));
      send(9960,  mk(10'h0FF, 1, 1));
      send(65535, mk(10'h0FF, 1, 55576));
      drain();

      // Backpressure in DONE with ignored requests
      out_ready = 1'b0;
      send(7539, mk(10'h0C1, 0, 0));
      n = 0;
      while (!out_valid && n < 30) begin
         tick();
         n++;
      end
      check("bp_out_valid_seen", int'(out_valid), 1);
      for (int i = 0; i < 5; i++) begin
         in_valid  = (i < 3);
         in_target = 16'd100;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_in_ready", int'(in_ready), 1);
      check("bp_release_out_valid", int'(out_valid), 0);
      send(1250, mk(10'h020, 0, 0));
      drain();

      // Reset mid-conversion at accept+4
      send(7539, mk(10'h0C1, 0, 0));
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      acc_q.delete();
      check("abort_in_ready", int'(in_ready), 1);
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_out_code", int'(out_code), 0);
      repeat (12) tick();
      send(1250, mk(10'h020, 0, 0));
      drain();

      // Random sweep against the reference model
      for (int k = 0; k < 200; k++) begin
         if (k % 10 == 0) t = int'($urandom_range(9900, 10100));
         else             t = int'($urandom_range(0, 10500));
         send(t, model(t));
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
